// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : ALU function codes, MIPS-I opcode/funct constants, decoded entry
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00011;
    localparam logic [4:0] ALU_NOR  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SLL  = 5'b00111;
    localparam logic [4:0] ALU_SLTU = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;
    localparam logic [4:0] ALU_SRL  = 5'b01010;
    localparam logic [4:0] ALU_BGEZ = 5'b10000;
    localparam logic [4:0] ALU_BGTZ = 5'b10001;
    localparam logic [4:0] ALU_BLEZ = 5'b10010;
    localparam logic [4:0] ALU_BLTZ = 5'b10011;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shft;
        logic [4:0]  aluctr;
        logic        is_branch;
        logic        br_inv;
        logic        ovf_trap;
        logic        illegal;
    } alu_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// alu_op_decode : combinational MIPS-I instr + GPR data -> decoded ALU entry
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output alu_entry_t  o_entry
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic        w_bad;
    logic        w_unused;
    alu_entry_t  w_d;

    assign w_op     = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_rt     = i_instr[20:16];
    assign w_sext   = {{16{i_instr[15]}}, i_instr[15:0]};
    assign w_zext   = {16'h0000, i_instr[15:0]};
    // The rs register number is resolved by register read before this stage.
    assign w_unused = ^i_instr[25:21];

    always_comb begin
        w_d       = '0;
        w_d.a     = i_rs_data;
        w_d.b     = i_rt_data;
        w_bad     = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD:  begin w_d.aluctr = ALU_ADD; w_d.ovf_trap = 1'b1; end
                    FN_ADDU: w_d.aluctr = ALU_ADD;
                    FN_SUB:  begin w_d.aluctr = ALU_SUB; w_d.ovf_trap = 1'b1; end
                    FN_SUBU: w_d.aluctr = ALU_SUB;
                    FN_AND:  w_d.aluctr = ALU_AND;
                    FN_OR:   w_d.aluctr = ALU_OR;
                    FN_XOR:  w_d.aluctr = ALU_XOR;
                    FN_NOR:  w_d.aluctr = ALU_NOR;
                    FN_SLT:  w_d.aluctr = ALU_SLT;
                    FN_SLTU: w_d.aluctr = ALU_SLTU;
                    FN_SLL:  begin w_d.aluctr = ALU_SLL; w_d.shft = i_instr[10:6]; end
                    FN_SRL:  begin w_d.aluctr = ALU_SRL; w_d.shft = i_instr[10:6]; end
                    FN_SRA:  begin w_d.aluctr = ALU_SRA; w_d.shft = i_instr[10:6]; end
                    FN_SLLV: begin w_d.aluctr = ALU_SLL; w_d.shft = i_rs_data[4:0]; end
                    FN_SRLV: begin w_d.aluctr = ALU_SRL; w_d.shft = i_rs_data[4:0]; end
                    FN_SRAV: begin w_d.aluctr = ALU_SRA; w_d.shft = i_rs_data[4:0]; end
                    default: w_bad = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                w_d.is_branch = 1'b1;
                if (w_rt == 5'd0)      w_d.aluctr = ALU_BLTZ;
                else if (w_rt == 5'd1) w_d.aluctr = ALU_BGEZ;
                else                   w_bad = 1'b1;
            end
            OP_BEQ:  begin w_d.aluctr = ALU_SUB;  w_d.is_branch = 1'b1; end
            OP_BNE:  begin w_d.aluctr = ALU_SUB;  w_d.is_branch = 1'b1; w_d.br_inv = 1'b1; end
            OP_BLEZ: begin w_d.aluctr = ALU_BLEZ; w_d.is_branch = 1'b1; end
            OP_BGTZ: begin w_d.aluctr = ALU_BGTZ; w_d.is_branch = 1'b1; end
            OP_ADDI: begin w_d.aluctr = ALU_ADD;  w_d.b = w_sext; w_d.ovf_trap = 1'b1; end
            OP_ADDIU, OP_LW, OP_SW: begin
                w_d.aluctr = ALU_ADD;
                w_d.b      = w_sext;
            end
            OP_SLTI:  begin w_d.aluctr = ALU_SLT;  w_d.b = w_sext; end
            OP_SLTIU: begin w_d.aluctr = ALU_SLTU; w_d.b = w_sext; end
            OP_ANDI:  begin w_d.aluctr = ALU_AND;  w_d.b = w_zext; end
            OP_ORI:   begin w_d.aluctr = ALU_OR;   w_d.b = w_zext; end
            OP_XORI:  begin w_d.aluctr = ALU_XOR;  w_d.b = w_zext; end
            OP_LUI:   begin w_d.aluctr = ALU_SLL;  w_d.b = w_zext; w_d.shft = 5'd16; end
            default:  w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_d         = '0;
            w_d.illegal = 1'b1;
        end
    end

    assign o_entry = w_d;

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage : decode + 2-entry skid buffer feeding EX via valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW      = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [4:0]    alu_shft,
    output logic [4:0]    aluctr,
    output logic          is_branch,
    output logic          br_inv,
    output logic          ovf_trap,
    output logic          illegal
);

    skid_state_t r_state;
    skid_state_t w_nxt;
    alu_entry_t  r_e0;
    alu_entry_t  r_e1;
    alu_entry_t  w_dec;
    logic        r_in_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_ld0_in;
    logic        w_ld1_in;
    logic        w_ld0_from1;

    alu_op_decode u_dec (
        .i_instr   (instr),
        .i_rs_data (rs_data),
        .i_rt_data (rt_data),
        .o_entry   (w_dec)
    );

    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = r_in_ready;
        end else begin : g_single
            // r_in_ready doubles as "out of reset" here since the state never reaches TWO.
            assign in_ready = r_in_ready & ((r_state == ST_EMPTY) | out_ready);
        end
    endgenerate

    always_comb begin
        w_nxt       = r_state;
        w_ld0_in    = 1'b0;
        w_ld1_in    = 1'b0;
        w_ld0_from1 = 1'b0;
        case (r_state)
            ST_EMPTY: if (w_push) begin
                w_nxt    = ST_ONE;
                w_ld0_in = 1'b1;
            end
            ST_ONE: begin
                if (w_push && !w_pop) begin
                    w_nxt    = ST_TWO;
                    w_ld1_in = 1'b1;
                end else if (w_push && w_pop) begin
                    w_ld0_in = 1'b1;
                end else if (w_pop) begin
                    w_nxt = ST_EMPTY;
                end
            end
            ST_TWO: if (w_pop) begin
                w_nxt       = ST_ONE;
                w_ld0_from1 = 1'b1;
            end
            default: w_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_nxt       = ST_EMPTY;
            w_ld0_in    = 1'b0;
            w_ld1_in    = 1'b0;
            w_ld0_from1 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_e0       <= '0;
            r_e1       <= '0;
        end else begin
            r_state    <= w_nxt;
            r_in_ready <= (w_nxt != ST_TWO);
            if (w_ld0_in)         r_e0 <= w_dec;
            else if (w_ld0_from1) r_e0 <= r_e1;
            if (w_ld1_in)         r_e1 <= w_dec;
        end
    end

    assign alu_a     = r_e0.a;
    assign alu_b     = r_e0.b;
    assign alu_shft  = r_e0.shft;
    assign aluctr    = r_e0.aluctr;
    assign is_branch = r_e0.is_branch;
    assign br_inv    = r_e0.br_inv;
    assign ovf_trap  = r_e0.ovf_trap;
    assign illegal   = r_e0.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// tb_alu_issue_stage : directed + random stimulus against a table-driven model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shft, aluctr;
    logic        is_branch, br_inv, ovf_trap, illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_stage #(.DW(32), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shft(alu_shft), .aluctr(aluctr),
        .is_branch(is_branch), .br_inv(br_inv), .ovf_trap(ovf_trap), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // kind: 0 sext imm, 1 zext imm, 2 lui, 3 register B; for R rows 0 none, 1 shamt, 2 rs[4:0]
    typedef struct packed {
        logic [5:0] key;
        logic [4:0] code;
        logic [1:0] kind;
        logic       br;
        logic       inv;
        logic       ovf;
    } row_t;

    typedef struct {
        logic [31:0] a, b;
        logic [4:0]  shft, ctr;
        logic        br, inv, ovf, ill;
    } exp_t;

    row_t r_tab[$];
    row_t i_tab[$];
    exp_t q[$];

    function automatic row_t mk(logic [5:0] k, logic [4:0] c, logic [1:0] kd,
                                logic b, logic v, logic o);
        row_t r;
        r.key = k; r.code = c; r.kind = kd; r.br = b; r.inv = v; r.ovf = o;
        return r;
    endfunction

    function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
        exp_t e;
        bit   hit = 0;
        e.a = rs; e.b = rt; e.shft = 0; e.ctr = 0;
        e.br = 0; e.inv = 0; e.ovf = 0; e.ill = 0;
        if (ins[31:26] == 6'd0) begin
            foreach (r_tab[i]) if (r_tab[i].key == ins[5:0]) begin
                hit   = 1;
                e.ctr = r_tab[i].code;
                e.ovf = r_tab[i].ovf;
                if (r_tab[i].kind == 2'd1) e.shft = ins[10:6];
                if (r_tab[i].kind == 2'd2) e.shft = rs[4:0];
            end
        end else if (ins[31:26] == 6'd1) begin
            e.br = 1;
            hit  = (ins[20:16] < 5'd2);
            e.ctr = (ins[20:16] == 5'd0) ? 5'd19 : 5'd16;
        end else begin
            foreach (i_tab[i]) if (i_tab[i].key == ins[31:26]) begin
                hit   = 1;
                e.ctr = i_tab[i].code;
                e.br  = i_tab[i].br;
                e.inv = i_tab[i].inv;
                e.ovf = i_tab[i].ovf;
                case (i_tab[i].kind)
                    2'd0: e.b = 32'(signed'(ins[15:0]));
                    2'd1: e.b = 32'(ins[15:0]);
                    2'd2: begin e.b = 32'(ins[15:0]); e.shft = 5'd16; end
                    default: e.b = rt;
                endcase
            end
        end
        if (!hit) begin
            e.a = 0; e.b = 0; e.shft = 0; e.ctr = 0;
            e.br = 0; e.inv = 0; e.ovf = 0; e.ill = 1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic iv, input logic ordy, input logic fl,
                         input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        bit push, pop;
        @(negedge clk);
        in_valid = iv; out_ready = ordy; flush = fl;
        instr = ins; rs_data = rs; rt_data = rt;
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready",  32'(in_ready),  32'(q.size() != 2));
        if (q.size() != 0) begin
            check("alu_a",     alu_a,            q[0].a);
            check("alu_b",     alu_b,            q[0].b);
            check("alu_shft",  32'(alu_shft),    32'(q[0].shft));
            check("aluctr",    32'(aluctr),      32'(q[0].ctr));
            check("is_branch", 32'(is_branch),   32'(q[0].br));
            check("br_inv",    32'(br_inv),      32'(q[0].inv));
            check("ovf_trap",  32'(ovf_trap),    32'(q[0].ovf));
            check("illegal",   32'(illegal),     32'(q[0].ill));
        end
        push = iv && (q.size() != 2);
        pop  = (q.size() != 0) && ordy;
        if (fl) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(ref_decode(ins, rs, rt));
        end
    endtask

    task automatic reset_now();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_alu_a",     alu_a,          32'd0);
        check("rst_alu_b",     alu_b,          32'd0);
        check("rst_aluctr",    32'(aluctr),    32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        if (k == 0) return w;
        if (k <= 4) return {6'd0, w[25:6], r_tab[$urandom_range(0, r_tab.size() - 1)].key};
        if (k <= 7) return {i_tab[$urandom_range(0, i_tab.size() - 1)].key, w[25:0]};
        if (k == 8) return {6'd1, w[25:21], 5'($urandom_range(0, 3)), w[15:0]};
        return {6'd0, w[25:0]};
    endfunction

    initial begin
        r_tab = '{mk(6'b100000,5'd0,2'd0,0,0,1), mk(6'b100001,5'd0,2'd0,0,0,0),
                  mk(6'b100010,5'd1,2'd0,0,0,1), mk(6'b100011,5'd1,2'd0,0,0,0),
                  mk(6'b100100,5'd3,2'd0,0,0,0), mk(6'b100101,5'd5,2'd0,0,0,0),
                  mk(6'b100110,5'd6,2'd0,0,0,0), mk(6'b100111,5'd4,2'd0,0,0,0),
                  mk(6'b101010,5'd2,2'd0,0,0,0), mk(6'b101011,5'd8,2'd0,0,0,0),
                  mk(6'b000000,5'd7,2'd1,0,0,0), mk(6'b000010,5'd10,2'd1,0,0,0),
                  mk(6'b000011,5'd9,2'd1,0,0,0), mk(6'b000100,5'd7,2'd2,0,0,0),
                  mk(6'b000110,5'd10,2'd2,0,0,0), mk(6'b000111,5'd9,2'd2,0,0,0)};
        i_tab = '{mk(6'b001000,5'd0,2'd0,0,0,1), mk(6'b001001,5'd0,2'd0,0,0,0),
                  mk(6'b100011,5'd0,2'd0,0,0,0), mk(6'b101011,5'd0,2'd0,0,0,0),
                  mk(6'b001010,5'd2,2'd0,0,0,0), mk(6'b001011,5'd8,2'd0,0,0,0),
                  mk(6'b001100,5'd3,2'd1,0,0,0), mk(6'b001101,5'd5,2'd1,0,0,0),
                  mk(6'b001110,5'd6,2'd1,0,0,0), mk(6'b001111,5'd7,2'd2,0,0,0),
                  mk(6'b000100,5'd1,2'd3,1,0,0), mk(6'b000101,5'd1,2'd3,1,1,0),
                  mk(6'b000110,5'd18,2'd3,1,0,0), mk(6'b000111,5'd17,2'd3,1,0,0)};

        #2;
        check("por_out_valid", 32'(out_valid), 32'd0);
        check("por_in_ready",  32'(in_ready),  32'd0);
        check("por_alu_b",     alu_b,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi $t0,$t1,-1 with rs = 5
        cycle(1, 1, 0, 32'h2128FFFF, 32'd5, 32'h0);
        cycle(0, 1, 0, 32'h0, 32'h0, 32'h0);
        check("addi_b",   alu_b,           32'hFFFFFFFF);
        check("addi_ovf", 32'(ovf_trap),   32'd1);

        // sra rd,rt,3 then srav with rs = 0x23; lui 0x1234; bne
        cycle(1, 1, 0, {6'd0, 5'd0, 5'd9, 5'd8, 5'd3, 6'b000011}, 32'h0, 32'h80000000);
        cycle(1, 1, 0, {6'd0, 5'd4, 5'd9, 5'd8, 5'd0, 6'b000111}, 32'h23, 32'h80000000);
        check("sra_shft", 32'(alu_shft), 32'd3);
        cycle(1, 1, 0, 32'h3C081234, 32'h0, 32'h0);
        check("srav_shft", 32'(alu_shft), 32'd3);
        check("srav_ctr",  32'(aluctr),   32'd9);
        cycle(1, 1, 0, 32'h1509FFF0, 32'd1, 32'd2);
        check("lui_b",    alu_b,           32'h00001234);
        check("lui_shft", 32'(alu_shft),   32'd16);
        cycle(0, 1, 0, 32'h0, 32'h0, 32'h0);
        check("bne_inv",  32'(br_inv),     32'd1);

        // stall with three pushes, then drain
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, rand_instr(), $urandom, $urandom);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'h0, 32'h0, 32'h0);

        // flush while full with a concurrent push
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, rand_instr(), $urandom, $urandom);
        cycle(1, 1, 1, 32'h20010001, 32'd7, 32'd0);
        cycle(0, 0, 0, 32'h0, 32'h0, 32'h0);

        // illegal REGIMM rt and illegal R-type funct
        cycle(1, 1, 0, {6'd1, 5'd3, 5'd2, 16'h0040}, $urandom, $urandom);
        cycle(1, 1, 0, {6'd0, 5'd3, 5'd2, 5'd1, 5'd0, 6'b001111}, $urandom, $urandom);
        cycle(0, 1, 0, 32'h0, 32'h0, 32'h0);
        check("illegal_r", 32'(illegal), 32'd1);
        cycle(0, 1, 0, 32'h0, 32'h0, 32'h0);

        // reset in the middle of a stall
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, rand_instr(), $urandom, $urandom);
        reset_now();

        for (int n = 0; n < 3000; n++)
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 31) == 0), rand_instr(), $urandom, $urandom);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
